// File: rtl/skinny_masked_pkg.sv
// Shared definitions for the masked Skinny-64 datapath.
// Holds the state geometry, S-box pipeline latency, the per-S-box fresh-randomness width,
// the run counter landmarks, the inverse S-box table and the FSM state encoding.
package skinny_masked_pkg;

   localparam int NIBBLES        = 16;
   localparam int SBOX_LAT       = 5;
   localparam int FRESH_PER_SBOX = 16;

   // Run counter landmarks: the last FEED cycle, the first capture cycle,
   // and the terminal count (the last DRAIN cycle).
   localparam logic [4:0] CNT_LAST_FEED = 5'(NIBBLES - 1);
   localparam logic [4:0] CNT_CAP_FIRST = 5'(SBOX_LAT);
   localparam logic [4:0] CNT_TERM      = 5'(NIBBLES + SBOX_LAT - 1);

   localparam logic [3:0] INV_SBOX [16] = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
                                            4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/nor_GHPC.sv
// Low-latency GHPC gadget computing a masked NOR of two 2-share bits, one register stage.
// For every possible value of the share-1 inputs, it precomputes NOR(share-0 ^ v) ^ r.
// After the register, it selects the entry that matches the registered share-1 inputs.
// Output share 0 is the mask r itself.
//   clk          rising-edge clock
//   a_s0, a_s1   shares of operand a
//   b_s0, b_s1   shares of operand b
//   fresh[3:0]   fresh randomness for this cycle
//   q_s0, q_s1   shares of ~(a | b), valid one cycle after the inputs
module nor_GHPC (
   input  logic       clk,
   input  logic       a_s0,
   input  logic       a_s1,
   input  logic       b_s0,
   input  logic       b_s1,
   input  logic [3:0] fresh,
   output logic       q_s0,
   output logic       q_s1
);

   logic       r;
   logic [3:0] tbl;
   logic [3:0] tbl_q;
   logic [1:0] sel_q;
   logic       r_q;

   // The XOR of all four fresh bits is still a uniform bit, so no fresh input goes unused.
   assign r = ^fresh;

   // Entry index = {a_s1, b_s1}.
   always_comb begin
      tbl    = '0;
      tbl[0] = ~( a_s0 |  b_s0) ^ r;
      tbl[1] = ~( a_s0 | ~b_s0) ^ r;
      tbl[2] = ~(~a_s0 |  b_s0) ^ r;
      tbl[3] = ~(~a_s0 | ~b_s0) ^ r;
   end

   always_ff @(posedge clk) begin
      tbl_q <= tbl;
      sel_q <= {a_s1, b_s1};
      r_q   <= r;
   end

   assign q_s0 = r_q;
   assign q_s1 = tbl_q[sel_q];

endmodule

// File: rtl/skinny_inv_sbox_GHPCLL_Pipeline_d1.sv
// First-order masked inverse Skinny 4-bit S-box, pipelined, latency 5.
// The inverse of the forward NOR/XOR network is four layers of x0 ^= ~(x3 | x2).
// Between layers, the bits are rotated: new (x3,x2,x1,x0) = old (x0,x3,x2,x1).
// Each NOR goes through one gadget stage. The other bits ride in a matching delay
// register (buf_clk). A final output register (reg_masked) follows the four layers.
//   clk              rising-edge clock
//   in_s0, in_s1     input nibble shares
//   Fresh[15:0]      4 fresh bits per layer, layer k uses Fresh[4k+3:4k]
//   out_s0, out_s1   output nibble shares, SBOX_LAT cycles after the input
module skinny_inv_sbox_GHPCLL_Pipeline_d1
   import skinny_masked_pkg::*;
(
   input  logic                      clk,
   input  logic [3:0]                in_s0,
   input  logic [3:0]                in_s1,
   input  logic [FRESH_PER_SBOX-1:0] Fresh,
   output logic [3:0]                out_s0,
   output logic [3:0]                out_s1
);

   logic [4:0][3:0] lay_s0;
   logic [4:0][3:0] lay_s1;

   assign lay_s0[0] = in_s0;
   assign lay_s1[0] = in_s1;

   for (genvar k = 0; k < 4; k++) begin : g_layer
      logic       nor_s0, nor_s1;
      logic [3:0] byp_s0, byp_s1;
      logic [3:0] mix_s0, mix_s1;

      nor_GHPC u_nor (
         .clk   (clk),
         .a_s0  (lay_s0[k][3]),
         .a_s1  (lay_s1[k][3]),
         .b_s0  (lay_s0[k][2]),
         .b_s1  (lay_s1[k][2]),
         .fresh (Fresh[4*k +: 4]),
         .q_s0  (nor_s0),
         .q_s1  (nor_s1)
      );

      // buf_clk: keeps the bypass bits aligned with the gadget output.
      always_ff @(posedge clk) begin
         byp_s0 <= lay_s0[k];
         byp_s1 <= lay_s1[k];
      end

      assign mix_s0 = {byp_s0[3:1], byp_s0[0] ^ nor_s0};
      assign mix_s1 = {byp_s1[3:1], byp_s1[0] ^ nor_s1};

      if (k < 3) begin : g_perm
         assign lay_s0[k+1] = {mix_s0[0], mix_s0[3:1]};
         assign lay_s1[k+1] = {mix_s1[0], mix_s1[3:1]};
      end else begin : g_last
         assign lay_s0[k+1] = mix_s0;
         assign lay_s1[k+1] = mix_s1;
      end
   end

   // reg_masked: final output register.
   always_ff @(posedge clk) begin
      out_s0 <= lay_s0[4];
      out_s1 <= lay_s1[4];
   end

endmodule

// File: rtl/skinny64_inv_subcells_serial_d1.sv
// Serialised first-order masked inverse SubCells for Skinny-64.
// Streams the 16 nibbles of a two-share state through one masked inverse S-box pipeline,
// one nibble per cycle, and reassembles the result.
//   clk, rst                    clock and synchronous active-high reset
//   start                       begin a run (accepted in IDLE or DONE)
//   state_in_s0/s1 [63:0]       input shares, sampled on an accepted start
//   Fresh [15:0]                fresh randomness, new every busy cycle
//   busy                        run in progress
//   done                        one-cycle pulse, state_out_* updated this cycle
//   state_out_s0/s1 [63:0]      output shares, stable between done pulses
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FEED  | nibble cnt enters the S-box (cnt 0..15)
// ST_DRAIN | pipeline empties, last captures (cnt 16..20)
// ST_DONE  | result visible, done pulse; a new start may be accepted
module skinny64_inv_subcells_serial_d1
   import skinny_masked_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [4*NIBBLES-1:0]      state_in_s0,
   input  logic [4*NIBBLES-1:0]      state_in_s1,
   input  logic [FRESH_PER_SBOX-1:0] Fresh,
   output logic                      busy,
   output logic                      done,
   output logic [4*NIBBLES-1:0]      state_out_s0,
   output logic [4*NIBBLES-1:0]      state_out_s1
);

   state_t               state_q, state_d;
   logic [4:0]           cnt_q;
   logic [4*NIBBLES-1:0] sh_s0, sh_s1;
   logic [4*NIBBLES-1:0] col_s0, col_s1;
   logic [3:0]           sb_out_s0, sb_out_s1;
   logic                 accept;

   assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_FEED;
         ST_FEED:  if (cnt_q == CNT_LAST_FEED) state_d = ST_DRAIN;
         ST_DRAIN: if (cnt_q == CNT_TERM) state_d = ST_DONE;
         ST_DONE:  state_d = start ? ST_FEED : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_FEED) || (state_q == ST_DRAIN);
      done = (state_q == ST_DONE);
   end

   skinny_inv_sbox_GHPCLL_Pipeline_d1 u_sbox (
      .clk    (clk),
      .in_s0  (sh_s0[3:0]),
      .in_s1  (sh_s1[3:0]),
      .Fresh  (Fresh),
      .out_s0 (sb_out_s0),
      .out_s1 (sb_out_s1)
   );

   // Input shift replicates the top nibble, so after nibble 15 is presented
   // it stays on the S-box input through DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         sh_s0        <= '0;
         sh_s1        <= '0;
         col_s0       <= '0;
         col_s1       <= '0;
         state_out_s0 <= '0;
         state_out_s1 <= '0;
      end else begin
         if (accept) begin
            cnt_q <= '0;
            sh_s0 <= state_in_s0;
            sh_s1 <= state_in_s1;
         end else begin
            if (busy) cnt_q <= cnt_q + 5'd1;
            if (state_q == ST_FEED) begin
               sh_s0 <= {sh_s0[63:60], sh_s0[63:4]};
               sh_s1 <= {sh_s1[63:60], sh_s1[63:4]};
            end
         end
         if (busy && (cnt_q >= CNT_CAP_FIRST)) begin
            col_s0 <= {sb_out_s0, col_s0[63:4]};
            col_s1 <= {sb_out_s1, col_s1[63:4]};
         end
         // The final capture goes straight to the outputs, so they are valid during DONE.
         if ((state_q == ST_DRAIN) && (cnt_q == CNT_TERM)) begin
            state_out_s0 <= {sb_out_s0, col_s0[63:4]};
            state_out_s1 <= {sb_out_s1, col_s1[63:4]};
         end
      end
   end

endmodule

// File: tb/tb_skinny64_inv_subcells_serial_d1.sv
module tb_skinny64_inv_subcells_serial_d1;
   import skinny_masked_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [63:0] in_s0, in_s1, out_s0, out_s1;
   logic [15:0] fresh = '0;
   logic        busy, done;

   int n_run  = 0;
   int n_fail = 0;

   logic [3:0] fwd_tbl [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

   always #5 clk = ~clk;

   skinny64_inv_subcells_serial_d1 dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .state_in_s0  (in_s0),
      .state_in_s1  (in_s1),
      .Fresh        (fresh),
      .busy         (busy),
      .done         (done),
      .state_out_s0 (out_s0),
      .state_out_s1 (out_s1)
   );

   initial forever begin
      @(posedge clk);
      #1 fresh = 16'($urandom);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] inv_ref(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = INV_SBOX[x[4*i +: 4]];
      return r;
   endfunction

   function automatic logic [63:0] fwd_ref(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = fwd_tbl[x[4*i +: 4]];
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts a run, returns the recombined output and the cycle index (t0 = 0) of done.
   task automatic run(input logic [63:0] s0, input logic [63:0] s1,
                      output logic [63:0] res, output int lat);
      in_s0 = s0; in_s1 = s1; start = 1'b1;
      tick;
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         tick;
         lat++;
      end
      res = out_s0 ^ out_s1;
   endtask

   initial begin
      logic [63:0] x, m, r, prev0, prev1;
      logic [63:0] vec [4];
      logic [63:0] exp_v [4];
      logic        seen;
      int          lat;

      rst = 1'b1; start = 1'b0; in_s0 = '0; in_s1 = '0;
      tick; tick;
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out0", out_s0, 64'd0);
      chk("rst_out1", out_s1, 64'd0);

      // Zero state, zero mask.
      run(64'd0, 64'd0, r, lat);
      chk("zero_lat", 64'(lat), 64'd22);
      chk("zero_out", r, 64'h3333333333333333);

      // Unmasked counting pattern with busy/done profile.
      in_s0 = 64'h0123456789ABCDEF; in_s1 = '0; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         chk($sformatf("prof_busy_c%0d", c), 64'(busy), 64'(c <= 21));
         chk($sformatf("prof_done_c%0d", c), 64'(done), 64'(c == 22));
         if (c < 22) tick;
      end
      chk("count_out", out_s0 ^ out_s1, 64'h3468CA1E92570BDF);

      // Random masks and states.
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom};
         m = {$urandom, $urandom};
         run(x ^ m, m, r, lat);
         chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd22);
         chk($sformatf("rnd%0d_out", i), r, inv_ref(x));
         chk($sformatf("rnd%0d_fwd", i), fwd_ref(r), x);
      end

      // Starts while busy are ignored.
      m = {$urandom, $urandom};
      in_s0 = 64'hFEDCBA9876543210 ^ m; in_s1 = m; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         chk($sformatf("ign_done_c%0d", c), 64'(done), 64'(c == 22));
         if (c == 5 || c == 15) begin
            start = 1'b1;
            in_s0 = {$urandom, $urandom};
            in_s1 = {$urandom, $urandom};
         end else begin
            start = 1'b0;
         end
         if (c < 22) tick;
      end
      chk("ign_out", out_s0 ^ out_s1, 64'hFDB07529E1AC8643);
      tick;
      chk("ign_single_done", 64'(done), 64'd0);

      // Reset mid-run.
      m = {$urandom, $urandom};
      in_s0 = 64'h0F1E2D3C4B5A6978 ^ m; in_s1 = m; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_out0", out_s0, 64'd0);
      chk("abort_out1", out_s1, 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         seen = seen | done;
         tick;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      m = {$urandom, $urandom};
      run(64'h0123456789ABCDEF ^ m, m, r, lat);
      chk("restart_lat", 64'(lat), 64'd22);
      chk("restart_out", r, 64'h3468CA1E92570BDF);
      tick;

      // Back-to-back runs, start in each DONE cycle.
      vec[0] = 64'h0123456789ABCDEF; exp_v[0] = 64'h3468CA1E92570BDF;
      vec[1] = 64'hFEDCBA9876543210; exp_v[1] = 64'hFDB07529E1AC8643;
      vec[2] = 64'h0;                exp_v[2] = 64'h3333333333333333;
      vec[3] = {$urandom, $urandom}; exp_v[3] = inv_ref(vec[3]);
      prev0 = '0; prev1 = '0;
      m = {$urandom, $urandom};
      in_s0 = vec[0] ^ m; in_s1 = m; start = 1'b1;
      for (int rn = 0; rn < 4; rn++) begin
         for (int c = 1; c <= 22; c++) begin
            tick;
            start = 1'b0;
            if (c < 22) begin
               chk($sformatf("b2b%0d_done_c%0d", rn, c), 64'(done), 64'd0);
               if (rn > 0) begin
                  chk($sformatf("b2b%0d_hold0_c%0d", rn, c), out_s0, prev0);
                  chk($sformatf("b2b%0d_hold1_c%0d", rn, c), out_s1, prev1);
               end
            end else begin
               chk($sformatf("b2b%0d_done", rn), 64'(done), 64'd1);
               chk($sformatf("b2b%0d_out", rn), out_s0 ^ out_s1, exp_v[rn]);
               prev0 = out_s0; prev1 = out_s1;
               if (rn < 3) begin
                  m = {$urandom, $urandom};
                  in_s0 = vec[rn+1] ^ m; in_s1 = m; start = 1'b1;
               end
            end
         end
      end
      tick;
      chk("b2b_end_done", 64'(done), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
